// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store alignment unit.
//   - lsu_state_t : controller states (IDLE, two memory-access phases, RESP)
//   - SZ_B/SZ_H/SZ_W/SZ_X : funct3[1:0] access-size codes (SZ_X is illegal)
//   - size_mask() : byte mask of an access before lane shifting
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   // Unshifted byte mask; the illegal code yields no bytes at all.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      logic [3:0] m;
      case (size)
         SZ_B:    m = 4'b0001;
         SZ_H:    m = 4'b0011;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane arithmetic for the alignment unit.
// Ports:
//   off        in  2   byte offset within the word (addr[1:0])
//   size       in  2   access size code
//   wdata      in  32  right-justified store data
//   word0      in  32  read data from the lower word
//   word1      in  32  read data from the upper word (0 when not split)
//   mask8      out 8   byte mask over the two-word window
//   crosses    out 1   access touches the upper word
//   data64     out 64  store data shifted into its byte lanes
//   load_data  out 32  right-justified load data, unused bytes zero
// ---------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [7:0]  mask8,
   output logic        crosses,
   output logic [63:0] data64,
   output logic [31:0] load_data
);

   logic [3:0]  szmask;
   logic [4:0]  bit_shift;
   logic [63:0] merged;
   logic [31:0] byte_mask;
   logic [31:0] unused_hi;

   assign szmask    = size_mask(size);
   assign bit_shift = {off, 3'b000};

   assign mask8   = {4'b0000, szmask} << off;
   assign crosses = |mask8[7:4];

   assign data64  = {32'h0, wdata} << bit_shift;

   // Bring the addressed byte down to bit 0 across the two-word window.
   assign merged    = {word1, word0} >> bit_shift;
   assign unused_hi = merged[63:32];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_mask
         assign byte_mask[gi*8 +: 8] = {8{szmask[gi]}};
      end
   endgenerate

   assign load_data = merged[31:0] & byte_mask;

endmodule

// File: rtl/lsu_mem_align.sv
// ---------------------------------------------------------------------------
// lsu_mem_align
// Load/store alignment unit between execute and the data-memory port.
// Converts byte-addressed B/H/W loads and stores into word-aligned memory
// accesses with byte enables; accesses that straddle a word boundary are
// split into two accesses (or rejected when SPLIT_MISALIGNED = 0).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, funct3, addr, wdata request fields
//   resp_valid/resp_rdata/resp_err  one-cycle completion pulse and result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  registered memory request
//   mem_ack/mem_rdata           memory completion and read data
// ---------------------------------------------------------------------------
module lsu_mem_align
   import lsu_pkg::*;
#(
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_reg, state_next;
   logic        we_reg, we_next;
   logic [1:0]  size_reg, size_next;
   logic [1:0]  off_reg, off_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] word0_reg, word0_next;
   logic        mem_req_reg, mem_req_next;
   logic        mem_we_reg, mem_we_next;
   logic [31:0] mem_addr_reg, mem_addr_next;
   logic [3:0]  mem_be_reg, mem_be_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic        resp_valid_reg, resp_valid_next;
   logic        resp_err_reg, resp_err_next;
   logic [31:0] resp_rdata_reg, resp_rdata_next;

   // funct3[2] only selects sign extension, which happens downstream.
   logic        unused_funct3;
   assign unused_funct3 = funct3[2];

   // Lane unit operands: while idle, look at the incoming request so the
   // first access can be issued on the accept edge; afterwards use the
   // captured request. Load merge takes the word arriving this cycle.
   logic        in_idle;
   logic [1:0]  la_off;
   logic [1:0]  la_size;
   logic [31:0] la_wdata;
   logic [31:0] la_word0;
   logic [31:0] la_word1;
   logic [7:0]  mask8;
   logic        crosses;
   logic [63:0] data64;
   logic [31:0] load_data;

   assign in_idle  = (state_reg == ST_IDLE);
   assign la_off   = in_idle ? addr[1:0]   : off_reg;
   assign la_size  = in_idle ? funct3[1:0] : size_reg;
   assign la_wdata = in_idle ? wdata       : wdata_reg;
   assign la_word0 = (state_reg == ST_ACC1) ? word0_reg : mem_rdata;
   assign la_word1 = (state_reg == ST_ACC1) ? mem_rdata : 32'h0;

   lsu_lane_align u_lane (
      .off       (la_off),
      .size      (la_size),
      .wdata     (la_wdata),
      .word0     (la_word0),
      .word1     (la_word1),
      .mask8     (mask8),
      .crosses   (crosses),
      .data64    (data64),
      .load_data (load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         we_reg         <= 1'b0;
         size_reg       <= SZ_B;
         off_reg        <= 2'b00;
         wdata_reg      <= 32'h0;
         word0_reg      <= 32'h0;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= 32'h0;
         mem_be_reg     <= 4'b0000;
         mem_wdata_reg  <= 32'h0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_rdata_reg <= 32'h0;
      end else begin
         state_reg      <= state_next;
         we_reg         <= we_next;
         size_reg       <= size_next;
         off_reg        <= off_next;
         wdata_reg      <= wdata_next;
         word0_reg      <= word0_next;
         mem_req_reg    <= mem_req_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_be_reg     <= mem_be_next;
         mem_wdata_reg  <= mem_wdata_next;
         resp_valid_reg <= resp_valid_next;
         resp_err_reg   <= resp_err_next;
         resp_rdata_reg <= resp_rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      we_next         = we_reg;
      size_next       = size_reg;
      off_next        = off_reg;
      wdata_next      = wdata_reg;
      word0_next      = word0_reg;
      mem_req_next    = mem_req_reg;
      mem_we_next     = mem_we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_be_next     = mem_be_reg;
      mem_wdata_next  = mem_wdata_reg;
      resp_valid_next = 1'b0;
      resp_err_next   = 1'b0;
      resp_rdata_next = resp_rdata_reg;

      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               we_next    = req_we;
               size_next  = funct3[1:0];
               off_next   = addr[1:0];
               wdata_next = wdata;
               if ((funct3[1:0] == SZ_X) || (crosses && (SPLIT_MISALIGNED == 0))) begin
                  state_next      = ST_RESP;
                  resp_valid_next = 1'b1;
                  resp_err_next   = 1'b1;
                  resp_rdata_next = 32'h0;
               end else begin
                  state_next     = ST_ACC0;
                  mem_req_next   = 1'b1;
                  mem_we_next    = req_we;
                  mem_addr_next  = {addr[31:2], 2'b00};
                  mem_be_next    = req_we ? mask8[3:0] : 4'b0000;
                  mem_wdata_next = req_we ? data64[31:0] : 32'h0;
               end
            end
         end

         ST_ACC0: begin
            if (mem_ack) begin
               word0_next = mem_rdata;
               if (crosses) begin
                  // Second word; the +4 wraps naturally at the top of memory.
                  state_next     = ST_ACC1;
                  mem_addr_next  = mem_addr_reg + 32'd4;
                  mem_be_next    = we_reg ? mask8[7:4] : 4'b0000;
                  mem_wdata_next = we_reg ? data64[63:32] : 32'h0;
               end else begin
                  state_next      = ST_RESP;
                  mem_req_next    = 1'b0;
                  mem_we_next     = 1'b0;
                  mem_be_next     = 4'b0000;
                  resp_valid_next = 1'b1;
                  resp_rdata_next = we_reg ? 32'h0 : load_data;
               end
            end
         end

         ST_ACC1: begin
            if (mem_ack) begin
               state_next      = ST_RESP;
               mem_req_next    = 1'b0;
               mem_we_next     = 1'b0;
               mem_be_next     = 4'b0000;
               resp_valid_next = 1'b1;
               resp_rdata_next = we_reg ? 32'h0 : load_data;
            end
         end

         ST_RESP: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign req_ready  = in_idle;
   assign resp_valid = resp_valid_reg;
   assign resp_err   = resp_err_reg;
   assign resp_rdata = resp_rdata_reg;
   assign mem_req    = mem_req_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_be     = mem_be_reg;
   assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_align.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_align
// Directed bench for lsu_mem_align. Instance u_dut splits misaligned
// accesses; instance u_nosplit rejects them. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lsu_mem_align;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_valid1;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   logic        req_ready1, resp_valid1, resp_err1, mem_req1, mem_we1;
   logic [31:0] resp_rdata1, mem_addr1, mem_wdata1;
   logic [3:0]  mem_be1;

   always #5 clk = ~clk;

   lsu_mem_align #(.SPLIT_MISALIGNED(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   lsu_mem_align #(.SPLIT_MISALIGNED(0)) u_nosplit (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_be(mem_be1), .mem_wdata(mem_wdata1),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
      end
   endtask

   // Results of the last run_op call.
   int          n_acc;
   logic [31:0] acc_addr [2];
   logic [31:0] acc_wd   [2];
   logic [3:0]  acc_be   [2];
   logic        acc_we   [2];
   logic [31:0] r_data;
   logic        r_err;
   int          r_cyc;
   bit          got_resp, stable_ok, ready_ok;

   // Issue one request to u_dut and act as memory: access k returns rd0/rd1
   // and is acknowledged after `waits` wait states. r_cyc counts falling
   // edges after the accept edge at which resp_valid is first seen.
   task automatic run_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input int waits, input bit hold_valid);
      int  wcnt;
      bit  prev_ack;
      n_acc = 0; got_resp = 0; stable_ok = 1; ready_ok = 1;
      r_data = 32'h0; r_err = 1'b0; r_cyc = 0;
      for (int k = 0; k < 2; k++) begin
         acc_addr[k] = 32'h0; acc_wd[k] = 32'h0; acc_be[k] = 4'h0; acc_we[k] = 1'b0;
      end
      @(negedge clk);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      prev_ack = 1'b0;
      wcnt = 0;
      for (int cyc = 1; cyc <= 60 && !got_resp; cyc++) begin
         @(negedge clk);
         if (!hold_valid) req_valid = 1'b0;
         mem_ack = 1'b0;
         if (req_ready) ready_ok = 0;
         if (resp_valid) begin
            got_resp  = 1;
            r_data    = resp_rdata;
            r_err     = resp_err;
            r_cyc     = cyc;
            req_valid = 1'b0;
            if (mem_req) stable_ok = 0;
         end else if (mem_req) begin
            if (prev_ack || n_acc == 0) begin
               if (n_acc < 2) begin
                  acc_addr[n_acc] = mem_addr; acc_wd[n_acc] = mem_wdata;
                  acc_be[n_acc]   = mem_be;   acc_we[n_acc] = mem_we;
               end
               n_acc++;
               wcnt = 0;
            end else if (n_acc <= 2) begin
               if (mem_addr !== acc_addr[n_acc-1] || mem_wdata !== acc_wd[n_acc-1] ||
                   mem_be !== acc_be[n_acc-1] || mem_we !== acc_we[n_acc-1])
                  stable_ok = 0;
            end
            mem_rdata = (n_acc == 1) ? rd0 : rd1;
            mem_ack   = (wcnt == waits);
            wcnt++;
         end
         prev_ack = mem_ack;
      end
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      check({name, "_resp_seen"}, {31'b0, got_resp}, 32'd1);
      check({name, "_stable"}, {31'b0, stable_ok}, 32'd1);
      check({name, "_busy"}, {31'b0, ready_ok}, 32'd1);
      $display("txn %s: we=%0d f3=%0d addr=0x%08h accesses=%0d rdata=0x%08h err=%0d cyc=%0d",
               name, we, f3, a, n_acc, r_data, r_err, r_cyc);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0; funct3 = 3'b010;
      addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_be", {28'b0, mem_be}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_ns_mem_req", {31'b0, mem_req1}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // mem_ack while idle must not start anything
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack_mem_req", {31'b0, mem_req}, 32'd0);
      check("idle_ack_resp", {31'b0, resp_valid}, 32'd0);

      // LW 0x100 aligned, immediate ack
      run_op("lw_aligned", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);
      check("lw_aligned_nacc", n_acc, 32'd1);
      check("lw_aligned_addr", acc_addr[0], 32'h100);
      check("lw_aligned_be", {28'b0, acc_be[0]}, 32'h0);
      check("lw_aligned_we", {31'b0, acc_we[0]}, 32'd0);
      check("lw_aligned_rdata", r_data, 32'hDEADBEEF);
      check("lw_aligned_err", {31'b0, r_err}, 32'd0);
      check("lw_aligned_cyc", r_cyc, 32'd2);

      // SB 0x103
      run_op("sb_off3", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 32'h0, 0, 0);
      check("sb_off3_nacc", n_acc, 32'd1);
      check("sb_off3_addr", acc_addr[0], 32'h100);
      check("sb_off3_be", {28'b0, acc_be[0]}, 32'h8);
      check("sb_off3_wdata", acc_wd[0], 32'hA5000000);
      check("sb_off3_we", {31'b0, acc_we[0]}, 32'd1);
      check("sb_off3_rdata", r_data, 32'h0);

      // LH 0x103 split
      run_op("lh_split", 1'b0, 3'b001, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 0, 0);
      check("lh_split_nacc", n_acc, 32'd2);
      check("lh_split_addr0", acc_addr[0], 32'h100);
      check("lh_split_addr1", acc_addr[1], 32'h104);
      check("lh_split_rdata", r_data, 32'h00008811);
      check("lh_split_cyc", r_cyc, 32'd3);

      // LHU decodes the same size; sign handling is downstream
      run_op("lhu_off2", 1'b0, 3'b101, 32'h202, 32'h0, 32'hF00DCAFE, 32'h0, 0, 0);
      check("lhu_off2_nacc", n_acc, 32'd1);
      check("lhu_off2_rdata", r_data, 32'h0000F00D);

      // SW 0x102 split
      run_op("sw_split", 1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 32'h0, 32'h0, 0, 0);
      check("sw_split_nacc", n_acc, 32'd2);
      check("sw_split_addr0", acc_addr[0], 32'h100);
      check("sw_split_be0", {28'b0, acc_be[0]}, 32'hC);
      check("sw_split_wd0", acc_wd[0], 32'hCCDD0000);
      check("sw_split_addr1", acc_addr[1], 32'h104);
      check("sw_split_be1", {28'b0, acc_be[1]}, 32'h3);
      check("sw_split_wd1", acc_wd[1], 32'h0000AABB);

      // LB with 3 wait states, req_valid held high throughout
      run_op("lb_wait", 1'b0, 3'b000, 32'h101, 32'h0, 32'h11223344, 32'h0, 3, 1);
      check("lb_wait_nacc", n_acc, 32'd1);
      check("lb_wait_addr", acc_addr[0], 32'h100);
      check("lb_wait_rdata", r_data, 32'h00000033);
      check("lb_wait_cyc", r_cyc, 32'd5);

      // LW 0xFFFFFFFD wraps to address 0
      run_op("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFD, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 0);
      check("lw_wrap_nacc", n_acc, 32'd2);
      check("lw_wrap_addr0", acc_addr[0], 32'hFFFFFFFC);
      check("lw_wrap_addr1", acc_addr[1], 32'h00000000);
      check("lw_wrap_rdata", r_data, 32'h44AABBCC);

      // Illegal size
      run_op("illegal", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0);
      check("illegal_nacc", n_acc, 32'd0);
      check("illegal_err", {31'b0, r_err}, 32'd1);
      check("illegal_cyc", r_cyc, 32'd1);

      // SPLIT_MISALIGNED=0 instance: misaligned LW rejected
      begin
         bit seen_req, seen_resp, err1;
         seen_req = 0; seen_resp = 0; err1 = 0;
         @(negedge clk);
         req_valid1 = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h101;
         @(negedge clk);
         req_valid1 = 1'b0;
         for (int cyc = 0; cyc < 6 && !seen_resp; cyc++) begin
            if (mem_req1) seen_req = 1;
            if (resp_valid1) begin seen_resp = 1; err1 = resp_err1; end
            @(negedge clk);
         end
         check("nosplit_resp", {31'b0, seen_resp}, 32'd1);
         check("nosplit_err", {31'b0, err1}, 32'd1);
         check("nosplit_no_mem", {31'b0, seen_req}, 32'd0);
         $display("txn nosplit_lw: addr=0x00000101 resp=%0d err=%0d mem_req_seen=%0d",
                  seen_resp, err1, seen_req);
      end

      // Async reset while waiting in the second access
      begin
         bit late_resp;
         late_resp = 0;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b001; addr = 32'h103;
         @(negedge clk);
         req_valid = 1'b0; mem_rdata = 32'h11223344; mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         check("rstmid_in_acc1_req", {31'b0, mem_req}, 32'd1);
         check("rstmid_in_acc1_addr", mem_addr, 32'h104);
         #2 reset = 1'b1;
         #1;
         check("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
         check("rstmid_ready", {31'b0, req_ready}, 32'd1);
         check("rstmid_resp", {31'b0, resp_valid}, 32'd0);
         @(negedge clk);
         reset = 1'b0;
         for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (resp_valid || mem_req) late_resp = 1;
         end
         check("rstmid_quiet", {31'b0, late_resp}, 32'd0);
         $display("txn reset_mid_acc1: quiet_after=%0d", !late_resp);
      end

      // Unit must be usable after the abandoned access
      run_op("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 32'h0, 1, 0);
      check("lw_after_rst_rdata", r_data, 32'h0BADF00D);
      check("lw_after_rst_cyc", r_cyc, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
